// File: rtl/core_ctrl_pkg.sv
// Shared control definitions for the RV32I multi-cycle sequencer: states,
// halt causes and the base opcode map.
package core_ctrl_pkg;

    localparam int unsigned OPCODE_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        HC_NONE    = 2'd0,
        HC_ILLEGAL = 2'd1,
        HC_SYSTEM  = 2'd2,
        HC_TIMEOUT = 2'd3
    } halt_cause_e;

    localparam logic [OPCODE_W-1:0] OPCODE_OP     = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OPCODE_SYSTEM = 7'b1110011;

    // SYSTEM is deliberately absent: it halts with its own cause.
    function automatic logic is_legal_opcode(input logic [OPCODE_W-1:0] opc);
        case (opc)
            OPCODE_OP, OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_STORE, OPCODE_BRANCH,
            OPCODE_JAL, OPCODE_JALR, OPCODE_LUI, OPCODE_AUIPC: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts unacknowledged handshake cycles; flags the cycle in which the wait
// would reach TIMEOUT. TIMEOUT of 0 never expires.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired = (TIMEOUT != 0) && tick && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the RV32I core: sequences fetch through
// writeback, runs the memory handshakes and issues datapath latch strobes.
module core_sequencer
    import core_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 dec_reg_wren,
    input  logic                 dec_ram_wren,
    input  logic                 dec_reg_write_data_src,
    output logic                 imem_req,
    input  logic                 imem_ack,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ack,
    output logic                 ir_wren,
    output logic                 alu_out_wren,
    output logic                 mdr_wren,
    output logic                 reg_wren,
    output logic                 pc_wren,
    output logic                 busy,
    output logic                 halted,
    output logic [1:0]           halt_cause,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instret
);

    state_e                state_q, state_d;
    halt_cause_e           halt_cause_q, halt_cause_d;
    logic [CNT_WIDTH-1:0]  cycle_count_q;
    logic [CNT_WIDTH-1:0]  instret_q;
    logic                  retire;
    logic                  tmr_tick;
    logic                  tmr_clear;
    logic                  tmr_expired;

    // One timer serves both handshakes; any state change restarts it.
    assign tmr_tick  = ((state_q == ST_FETCH) && !imem_ack) ||
                       ((state_q == ST_MEM)   && !dmem_ack);
    assign tmr_clear = (state_d != state_q);

    mem_wait_timer #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .tick    (tmr_tick),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d      = state_q;
        halt_cause_d = halt_cause_q;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_wren      = 1'b0;
        alu_out_wren = 1'b0;
        mdr_wren     = 1'b0;
        reg_wren     = 1'b0;
        pc_wren      = 1'b0;
        retire       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_wren = 1'b1;
                    state_d = ST_DECODE;
                end else if (tmr_expired) begin
                    state_d      = ST_HALT;
                    halt_cause_d = HC_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (opcode == OPCODE_SYSTEM) begin
                    state_d      = ST_HALT;
                    halt_cause_d = HC_SYSTEM;
                end else if (!is_legal_opcode(opcode)) begin
                    state_d      = ST_HALT;
                    halt_cause_d = HC_ILLEGAL;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                alu_out_wren = 1'b1;
                if (dec_ram_wren || (dec_reg_wren && dec_reg_write_data_src)) begin
                    state_d = ST_MEM;
                end else if (dec_reg_wren) begin
                    state_d = ST_WRITEBACK;
                end else begin
                    pc_wren = 1'b1;
                    retire  = 1'b1;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_ram_wren;
                if (dmem_ack) begin
                    if (dec_ram_wren) begin
                        pc_wren = 1'b1;
                        retire  = 1'b1;
                    end else begin
                        mdr_wren = 1'b1;
                        state_d  = ST_WRITEBACK;
                    end
                end else if (tmr_expired) begin
                    state_d      = ST_HALT;
                    halt_cause_d = HC_TIMEOUT;
                end
            end
            ST_WRITEBACK: begin
                reg_wren = 1'b1;
                pc_wren  = 1'b1;
                retire   = 1'b1;
            end
            default: ;
        endcase

        if (retire) state_d = run ? ST_FETCH : ST_IDLE;

        // Nothing latches in the datapath while reset is applied.
        if (rst) begin
            ir_wren      = 1'b0;
            alu_out_wren = 1'b0;
            mdr_wren     = 1'b0;
            reg_wren     = 1'b0;
            pc_wren      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            halt_cause_q  <= HC_NONE;
            cycle_count_q <= '0;
            instret_q     <= '0;
        end else begin
            state_q      <= state_d;
            halt_cause_q <= halt_cause_d;
            if (busy)    cycle_count_q <= cycle_count_q + CNT_WIDTH'(1);
            if (pc_wren) instret_q     <= instret_q + CNT_WIDTH'(1);
        end
    end

    assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted      = (state_q == ST_HALT);
    assign halt_cause  = halt_cause_q;
    assign cycle_count = cycle_count_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: per-cycle strobe vectors for each
// instruction class, halts, handshake timeouts and reset/run interactions.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rst, run, imem_ack, dmem_ack;
    logic        dec_reg_wren, dec_ram_wren, dec_reg_write_data_src;
    logic [6:0]  opcode;
    logic        imem_req, dmem_req, dmem_we;
    logic        ir_wren, alu_out_wren, mdr_wren, reg_wren, pc_wren;
    logic        busy, halted;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_count, instret;
    logic [7:0]  obs;

    int checks   = 0;
    int failures = 0;

    core_sequencer #(
        .CNT_WIDTH   (32),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .run                    (run),
        .opcode                 (opcode),
        .dec_reg_wren           (dec_reg_wren),
        .dec_ram_wren           (dec_ram_wren),
        .dec_reg_write_data_src (dec_reg_write_data_src),
        .imem_req               (imem_req),
        .imem_ack               (imem_ack),
        .dmem_req               (dmem_req),
        .dmem_we                (dmem_we),
        .dmem_ack               (dmem_ack),
        .ir_wren                (ir_wren),
        .alu_out_wren           (alu_out_wren),
        .mdr_wren               (mdr_wren),
        .reg_wren               (reg_wren),
        .pc_wren                (pc_wren),
        .busy                   (busy),
        .halted                 (halted),
        .halt_cause             (halt_cause),
        .cycle_count            (cycle_count),
        .instret                (instret)
    );

    always #5 clk = ~clk;

    // {imem_req, dmem_req, dmem_we, ir, alu_out, mdr, reg, pc}
    assign obs = {imem_req, dmem_req, dmem_we, ir_wren, alu_out_wren, mdr_wren, reg_wren, pc_wren};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic [6:0] opc, input logic regw, input logic ramw, input logic src);
        opcode = opc; dec_reg_wren = regw; dec_ram_wren = ramw; dec_reg_write_data_src = src;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        set_dec(7'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
        set_dec(7'b0110011, 1'b1, 1'b0, 1'b0);
        cyc();
        cyc();
        #1;
        checks++;
        if (obs !== 8'h00) begin failures++; $display("FAIL reset_strobes_in_rst: got %h exp 00", obs); end
        rst = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        #1;
        checks++;
        if (obs !== 8'h00) begin failures++; $display("FAIL reset_strobes: got %h exp 00", obs); end
        checks++;
        if (busy !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL reset_status: got busy=%b halted=%b exp 0 0", busy, halted); end
        checks++;
        if (halt_cause !== 2'd0) begin failures++; $display("FAIL reset_cause: got %0d exp 0", halt_cause); end
        checks++;
        if (cycle_count !== 32'd0 || instret !== 32'd0) begin failures++; $display("FAIL reset_counters: got %0d/%0d exp 0/0", cycle_count, instret); end
    endtask

    task automatic test_add();
        logic [2:0] in_v  [5] = '{3'b100, 3'b110, 3'b100, 3'b100, 3'b100};
        logic [7:0] exp_v [5] = '{8'h00, 8'h90, 8'h00, 8'h08, 8'h03};
        logic       bsy_v [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        do_reset();
        set_dec(7'b0110011, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            {run, imem_ack, dmem_ack} = in_v[i];
            #1;
            checks++;
            if (obs !== exp_v[i]) begin failures++; $display("FAIL add_strobes c%0d: got %h exp %h", i, obs, exp_v[i]); end
            checks++;
            if (busy !== bsy_v[i]) begin failures++; $display("FAIL add_busy c%0d: got %b exp %b", i, busy, bsy_v[i]); end
            cyc();
        end
        {run, imem_ack, dmem_ack} = 3'b000;
        #1;
        checks++;
        if (imem_req !== 1'b1) begin failures++; $display("FAIL add_refetch: got %b exp 1", imem_req); end
        checks++;
        if (instret !== 32'd1) begin failures++; $display("FAIL add_instret: got %0d exp 1", instret); end
        checks++;
        if (cycle_count !== 32'd4) begin failures++; $display("FAIL add_cycles: got %0d exp 4", cycle_count); end
    endtask

    task automatic test_load();
        logic [2:0] in_v  [10] = '{3'b100, 3'b110, 3'b100, 3'b100, 3'b100,
                                   3'b100, 3'b100, 3'b101, 3'b000, 3'b000};
        logic [7:0] exp_v [10] = '{8'h00, 8'h90, 8'h00, 8'h08, 8'h40,
                                   8'h40, 8'h40, 8'h44, 8'h03, 8'h00};
        do_reset();
        set_dec(7'b0000011, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            {run, imem_ack, dmem_ack} = in_v[i];
            #1;
            checks++;
            if (obs !== exp_v[i]) begin failures++; $display("FAIL load_strobes c%0d: got %h exp %h", i, obs, exp_v[i]); end
            cyc();
        end
        checks++;
        if (instret !== 32'd1 || cycle_count !== 32'd8) begin failures++; $display("FAIL load_counters: got %0d/%0d exp 1/8", instret, cycle_count); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] in_v  [9] = '{3'b100, 3'b110, 3'b100, 3'b100, 3'b101,
                                  3'b110, 3'b100, 3'b000, 3'b000};
        logic [7:0] exp_v [9] = '{8'h00, 8'h90, 8'h00, 8'h08, 8'h61,
                                  8'h90, 8'h00, 8'h09, 8'h00};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i < 5) set_dec(7'b0100011, 1'b0, 1'b1, 1'b0);
            else       set_dec(7'b1100011, 1'b0, 1'b0, 1'b0);
            {run, imem_ack, dmem_ack} = in_v[i];
            #1;
            checks++;
            if (obs !== exp_v[i]) begin failures++; $display("FAIL st_br_strobes c%0d: got %h exp %h", i, obs, exp_v[i]); end
            cyc();
        end
        checks++;
        if (instret !== 32'd2 || cycle_count !== 32'd7) begin failures++; $display("FAIL st_br_counters: got %0d/%0d exp 2/7", instret, cycle_count); end
    endtask

    task automatic test_decode_halt(input logic [6:0] opc, input logic [1:0] cause);
        logic [2:0] in_v [7] = '{3'b100, 3'b110, 3'b100, 3'b110, 3'b110, 3'b111, 3'b110};
        do_reset();
        set_dec(opc, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            {run, imem_ack, dmem_ack} = in_v[i];
            #1;
            if (i != 1) begin
                checks++;
                if (obs !== 8'h00) begin failures++; $display("FAIL halt%0d_strobes c%0d: got %h exp 00", cause, i, obs); end
            end
            if (i >= 3) begin
                checks++;
                if (halted !== 1'b1 || busy !== 1'b0 || halt_cause !== cause) begin
                    failures++;
                    $display("FAIL halt%0d_status c%0d: got halted=%b busy=%b cause=%0d exp 1 0 %0d", cause, i, halted, busy, halt_cause, cause);
                end
            end
            cyc();
        end
        checks++;
        if (instret !== 32'd0) begin failures++; $display("FAIL halt%0d_instret: got %0d exp 0", cause, instret); end
        rst = 1'b1;
        cyc();
        rst = 1'b0; run = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || halt_cause !== 2'd0) begin failures++; $display("FAIL halt%0d_clear: got halted=%b cause=%0d exp 0 0", cause, halted, halt_cause); end
    endtask

    task automatic test_timeout();
        logic [2:0] a_in  [6] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
        logic [7:0] a_exp [6] = '{8'h00, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00};
        logic [2:0] b_in  [7] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b110, 3'b100, 3'b100};
        logic [7:0] b_exp [7] = '{8'h00, 8'h80, 8'h80, 8'h80, 8'h90, 8'h00, 8'h08};
        logic [2:0] c_in  [9] = '{3'b100, 3'b110, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
        logic [7:0] c_exp [9] = '{8'h00, 8'h90, 8'h00, 8'h08, 8'h40, 8'h40, 8'h40, 8'h40, 8'h00};
        do_reset();
        set_dec(7'b0110011, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            {run, imem_ack, dmem_ack} = a_in[i];
            #1;
            checks++;
            if (obs !== a_exp[i]) begin failures++; $display("FAIL ifetch_to_strobes c%0d: got %h exp %h", i, obs, a_exp[i]); end
            cyc();
        end
        checks++;
        if (halted !== 1'b1 || halt_cause !== 2'd3) begin failures++; $display("FAIL ifetch_to_cause: got halted=%b cause=%0d exp 1 3", halted, halt_cause); end

        do_reset();
        set_dec(7'b0110011, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            {run, imem_ack, dmem_ack} = b_in[i];
            #1;
            checks++;
            if (obs !== b_exp[i]) begin failures++; $display("FAIL ack_wins_strobes c%0d: got %h exp %h", i, obs, b_exp[i]); end
            cyc();
        end
        checks++;
        if (halted !== 1'b0 || halt_cause !== 2'd0) begin failures++; $display("FAIL ack_wins_status: got halted=%b cause=%0d exp 0 0", halted, halt_cause); end

        do_reset();
        set_dec(7'b0000011, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            {run, imem_ack, dmem_ack} = c_in[i];
            #1;
            checks++;
            if (obs !== c_exp[i]) begin failures++; $display("FAIL dmem_to_strobes c%0d: got %h exp %h", i, obs, c_exp[i]); end
            cyc();
        end
        checks++;
        if (halted !== 1'b1 || halt_cause !== 2'd3 || instret !== 32'd0) begin
            failures++;
            $display("FAIL dmem_to_status: got halted=%b cause=%0d instret=%0d exp 1 3 0", halted, halt_cause, instret);
        end
    endtask

    task automatic test_run_drop();
        logic [2:0] in_v  [7] = '{3'b100, 3'b110, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
        logic [7:0] exp_v [7] = '{8'h00, 8'h90, 8'h00, 8'h08, 8'h03, 8'h00, 8'h00};
        do_reset();
        set_dec(7'b0110011, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            {run, imem_ack, dmem_ack} = in_v[i];
            #1;
            checks++;
            if (obs !== exp_v[i]) begin failures++; $display("FAIL run_drop_strobes c%0d: got %h exp %h", i, obs, exp_v[i]); end
            cyc();
        end
        checks++;
        if (instret !== 32'd1 || busy !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL run_drop_idle: got instret=%0d busy=%b halted=%b exp 1 0 0", instret, busy, halted);
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [2:0] in_v  [5] = '{3'b100, 3'b110, 3'b100, 3'b100, 3'b100};
        logic [7:0] exp_v [5] = '{8'h00, 8'h90, 8'h00, 8'h08, 8'h40};
        do_reset();
        set_dec(7'b0000011, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            {run, imem_ack, dmem_ack} = in_v[i];
            #1;
            checks++;
            if (obs !== exp_v[i]) begin failures++; $display("FAIL rst_mem_strobes c%0d: got %h exp %h", i, obs, exp_v[i]); end
            cyc();
        end
        rst = 1'b1; dmem_ack = 1'b1;
        #1;
        checks++;
        if (obs !== 8'h40) begin failures++; $display("FAIL rst_mem_rst_cycle: got %h exp 40", obs); end
        cyc();
        rst = 1'b0; dmem_ack = 1'b0; run = 1'b0;
        #1;
        checks++;
        if (obs !== 8'h00 || busy !== 1'b0) begin failures++; $display("FAIL rst_mem_after: got strobes=%h busy=%b exp 00 0", obs, busy); end
        checks++;
        if (cycle_count !== 32'd0 || instret !== 32'd0) begin failures++; $display("FAIL rst_mem_counters: got %0d/%0d exp 0/0", cycle_count, instret); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish exp finish before 200000");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_load();
        test_back_to_back();
        test_decode_halt(7'b0000000, 2'd1);
        test_decode_halt(7'b1110011, 2'd2);
        test_timeout();
        test_run_drop();
        test_reset_mid_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback around the combinational instruction decoder, ALU, register file and RAM.
- It consumes the decoder's per-instruction write enables and turns them into single-cycle strobes gated by state.
- It runs the req/ack handshakes to instruction and data memory, and halts on illegal opcodes, SYSTEM instructions or memory timeout.
- It sits between the core top level and the datapath, and owns the PC, IR and ALU-output latch enables.

Parameters:
- CNT_WIDTH, 32, width of the cycle_count and instret counters.
- MEM_TIMEOUT, 255, max wait cycles per memory handshake. 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- run  in  1  level; 1 = execute instructions
- opcode  in  7  instruction[6:0] from the IR
- dec_reg_wren  in  1  decoder register write enable
- dec_ram_wren  in  1  decoder RAM write enable (1 = store)
- dec_reg_write_data_src  in  1  decoder writeback source (1 = RAM, i.e. load)
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (valid with dmem_req)
- dmem_ack  in  1  data access complete (read data valid)
- ir_wren  out  1  latch instruction register
- alu_out_wren  out  1  latch ALU result register
- mdr_wren  out  1  latch load data register
- reg_wren  out  1  register file write strobe
- pc_wren  out  1  PC update strobe (one per retired instruction)
- busy  out  1  1 when state is not IDLE and not HALT
- halted  out  1  1 in HALT
- halt_cause  out  2  0 none, 1 illegal, 2 ecall/ebreak, 3 memory timeout
- cycle_count  out  CNT_WIDTH  cycles while busy
- instret  out  CNT_WIDTH  retired instruction count

Behaviour:
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
- Reset: state IDLE. All strobes, imem_req, dmem_req and dmem_we are 0. busy=0, halted=0, halt_cause=0. Counters and timer are 0.
- Reset mid-operation: rst in any state, including mid-handshake, drops imem_req and dmem_req the next cycle. No strobe fires in the reset cycle.
- IDLE: run=1 -> FETCH next cycle. Otherwise stay.
- FETCH: imem_req=1 for every cycle in FETCH.
  - imem_ack=1 -> ir_wren=1 in that same cycle (Mealy), then -> DECODE.
  - An ack in the first FETCH cycle is valid.
  - imem_ack is ignored outside FETCH.
- DECODE: exactly one cycle. Check opcode against the legal set {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111}.
  - opcode 1110011 -> HALT with cause 2.
  - Any other opcode outside the legal set -> HALT with cause 1.
  - Legal opcode -> EXECUTE.
- EXECUTE: exactly one cycle, alu_out_wren=1. Next state by instruction class:
  - dec_ram_wren=1 (store) -> MEM.
  - dec_reg_write_data_src=1 with dec_reg_wren=1 (load) -> MEM.
  - dec_reg_wren=1 otherwise -> WRITEBACK.
  - Neither write enable (branch) -> retire here: pc_wren=1 in this cycle.
- MEM: dmem_req=1 for every cycle in MEM. dmem_we=dec_ram_wren.
  - Store: on dmem_ack, pc_wren=1 (retire).
  - Load: on dmem_ack, mdr_wren=1, then -> WRITEBACK.
- WRITEBACK: exactly one cycle. reg_wren=1 and pc_wren=1 (retire).
- Retire boundary: the cycle with pc_wren=1.
  - instret increments in that cycle.
  - Next state is FETCH if run=1, else IDLE.
  - Deasserting run mid-instruction never aborts the instruction.
- Timeout:
  - The wait timer resets on entry to FETCH or MEM and increments each cycle without ack.
  - Timer reaches MEM_TIMEOUT with no ack -> HALT with cause 3. The request drops the next cycle.
  - Ack and timeout in the same cycle: ack wins.
- HALT: sticky until rst. All strobes 0. halt_cause holds its value. No retire occurs for the halting instruction.
- Strobes are asserted only from state and the stated acks. reg_wren and dmem_we are never 1 outside WRITEBACK and MEM respectively.
- Counters: cycle_count increments every cycle busy=1. Both counters wrap modulo 2^CNT_WIDTH.

Decomposition:
- Shared package core_ctrl_pkg:
  - state enum.
  - halt_cause codes.
  - OPCODE_SYSTEM constant.
  - The legal-opcode set reuses the existing shared opcode defines.
- One sub-module: mem_wait_timer, with inputs clear and tick and output expired. Instantiate once, shared by FETCH and MEM.

Test Plan:
1. ADD (opcode 0110011, dec_reg_wren=1), run=1, imem_ack on the first FETCH cycle -> states F,D,E,WB; ir_wren at cycle 1, alu_out_wren at cycle 3, reg_wren and pc_wren together at cycle 4; instret=1; cycle_count=4.
2. LW (0000011, dec_reg_write_data_src=1), dmem_ack 3 cycles after MEM entry -> dmem_req high 4 cycles, dmem_we=0; mdr_wren on the ack cycle; WRITEBACK the next cycle with reg_wren=1.
3. SW (0100011) then BEQ (1100011) -> store retires on the dmem_ack cycle with dmem_we=1 and reg_wren never 1; branch retires in EXECUTE (pc_wren there, no MEM or WB); instret=2.
4. Illegal opcode 0000000 -> HALT after DECODE, halt_cause=1, halted=1; no pc_wren; stays halted with run=1 until rst. Repeat with 1110011 -> halt_cause=2.
5. MEM_TIMEOUT=4, imem_ack held 0 -> imem_req high exactly 4 cycles, then HALT with halt_cause=3. Ack in the same cycle as expiry -> normal DECODE instead.
6. run dropped during EXECUTE of an ADD -> WB completes, instret increments, then IDLE. rst asserted during MEM -> IDLE next cycle, dmem_req=0, counters=0.
